rf_operand_sequencer: RTL and testbench

//  Initiator side of the 4x8 register-file port. Accepts one decoded ALU instruction per handshake.

---
 rtl/rf_operand_sequencer_pkg.sv | 28 ++
 rtl/rf_operand_sequencer_alu.sv | 45 ++++
 rtl/rf_operand_sequencer.sv | 126 ++++++++++++
 tb/tb_rf_operand_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_operand_sequencer_pkg.sv
// ============================================================================
// Module : rf_operand_sequencer_pkg
// Brief  : Opcode and FSM state encodings shared by the operand sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_operand_sequencer_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_LI   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rf_operand_sequencer_alu.sv
// ============================================================================
// Module : rf_operand_sequencer_alu
// Brief  : Combinational ALU; carry is bit DATA_W of the widened sum/difference.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_operand_sequencer_alu
  import rf_operand_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, a} + {1'b0, b};
    w_diff = {1'b0, a} - {1'b0, b};
    result = {DATA_W{1'b0}};
    carry  = 1'b0;
    case (op[2:0])
      OP_ADD:  begin result = w_sum[DATA_W-1:0];  carry = w_sum[DATA_W];  end
      OP_SUB:  begin result = w_diff[DATA_W-1:0]; carry = w_diff[DATA_W]; end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_PASS: result = a;
      OP_LI:   result = imm;
      default: result = {DATA_W{1'b0}};
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rf_operand_sequencer.sv
// ============================================================================
// Module : rf_operand_sequencer
// Brief  : Reads rs/rt from the register file, executes, writes acc back to rd.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_operand_sequencer
  import rf_operand_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [ADDR_W-1:0] instr_rt,
  input  logic [DATA_W-1:0] instr_imm,
  output logic              rf_ren_wen,
  output logic [ADDR_W-1:0] rf_readaddr1,
  output logic [ADDR_W-1:0] rf_readaddr2,
  output logic [ADDR_W-1:0] rf_writeaddr,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic [DATA_W-1:0] acc,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              done
);

  state_t            r_state;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_imm;
  logic [ADDR_W-1:0] r_raddr1;
  logic [ADDR_W-1:0] r_raddr2;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_acc;
  logic              r_zero;
  logic              r_carry;
  logic              r_done;
  logic              r_wen;

  logic [DATA_W-1:0] w_result;
  logic              w_carry;

  rf_operand_sequencer_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .op     (r_op),
    .a      (rf_data1),
    .b      (rf_data2),
    .imm    (r_imm),
    .result (w_result),
    .carry  (w_carry)
  );

  // The read-address registers double as the latched rs/rt fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      r_raddr1 <= '0;
      r_raddr2 <= '0;
      r_waddr  <= '0;
      r_acc    <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_wen    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wen  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op     <= instr_op;
            r_rd     <= instr_rd;
            r_imm    <= instr_imm;
            r_raddr1 <= instr_rs;
            r_raddr2 <= instr_rt;
            r_state  <= S_READ;
          end
        end
        S_READ: r_state <= S_EXEC;
        S_EXEC: begin
          r_acc   <= w_result;
          r_zero  <= (w_result == {DATA_W{1'b0}});
          r_carry <= w_carry;
          r_done  <= 1'b1;
          // A write to r0 is dropped: retire straight back to IDLE.
          if (r_rd == {ADDR_W{1'b0}}) begin
            r_state <= S_IDLE;
          end else begin
            r_wen   <= 1'b1;
            r_waddr <= r_rd;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready  = (r_state == S_IDLE);
  assign rf_ren_wen   = r_wen;
  assign rf_readaddr1 = r_raddr1;
  assign rf_readaddr2 = r_raddr2;
  assign rf_writeaddr = r_waddr;
  assign acc          = r_acc;
  assign flag_zero    = r_zero;
  assign flag_carry   = r_carry;
  assign done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rf_operand_sequencer.sv
// ============================================================================
// Module : tb_rf_operand_sequencer
// Brief  : Register-file model, instruction-level reference model and directed tests.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = '0;
  logic [1:0] instr_rd = '0;
  logic [1:0] instr_rs = '0;
  logic [1:0] instr_rt = '0;
  logic [7:0] instr_imm = '0;
  logic       rf_ren_wen;
  logic [1:0] rf_readaddr1, rf_readaddr2, rf_writeaddr;
  logic [7:0] rf_data1 = '0;
  logic [7:0] rf_data2 = '0;
  logic [7:0] acc;
  logic       flag_zero, flag_carry, done;

  int checks = 0;
  int errors = 0;

  rf_operand_sequencer dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_rt(instr_rt), .instr_imm(instr_imm),
    .rf_ren_wen(rf_ren_wen), .rf_readaddr1(rf_readaddr1),
    .rf_readaddr2(rf_readaddr2), .rf_writeaddr(rf_writeaddr),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .acc(acc), .flag_zero(flag_zero), .flag_carry(flag_carry), .done(done)
  );

  always #5 clk = ~clk;

  // Register file: r0 reads as zero, reads return data one cycle later.
  logic [7:0] mem [4] = '{default: 8'h00};
  always @(posedge clk) begin
    if (rf_ren_wen) begin
      if (rf_writeaddr != 2'd0) mem[rf_writeaddr] <= acc;
    end else begin
      rf_data1 <= (rf_readaddr1 == 2'd0) ? 8'h00 : mem[rf_readaddr1];
      rf_data2 <= (rf_readaddr2 == 2'd0) ? 8'h00 : mem[rf_readaddr2];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {carry, result[7:0]} from plain integer arithmetic.
  function automatic int alu_ref(input int op, input int a, input int b, input int imm);
    int s;
    case (op)
      0: return a + b;
      1: begin s = a - b; return ((s < 0) ? 256 : 0) + ((s + 256) % 256); end
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (a < b) ? 1 : 0;
      6: return a;
      default: return imm;
    endcase
  endfunction

  // Instruction-level model: phase 0 idle, phases 1..3 count cycles after acceptance.
  int cnt = 0, cyc = 0;
  int p_rd = 0, p_rs = 0, p_rt = 0, p_ret = 0;
  int m_acc = 0, m_zero = 0, m_carry = 0;
  int m_regs [4] = '{0, 0, 0, 0};
  bit rdy;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      cnt = 0; m_acc = 0; m_zero = 0; m_carry = 0;
    end else begin
      cyc++;
      if (cnt == 2) begin
        m_acc   = p_ret % 256;
        m_carry = p_ret / 256;
        m_zero  = (m_acc == 0) ? 1 : 0;
      end
      if (cnt == 3 && p_rd != 0) m_regs[p_rd] = m_acc;
      rdy = (cnt == 0) || (cnt == 3 && p_rd == 0);
      cnt = (cnt == 0 || cnt == 3) ? 0 : cnt + 1;
      if (rdy && instr_valid) begin
        p_rd  = int'(instr_rd);
        p_rs  = int'(instr_rs);
        p_rt  = int'(instr_rt);
        p_ret = alu_ref(int'(instr_op), m_regs[p_rs], m_regs[p_rt], int'(instr_imm));
        cnt   = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("ready", int'(instr_ready), ((cnt == 0) || (cnt == 3 && p_rd == 0)) ? 1 : 0);
      chk("done", int'(done), (cnt == 3) ? 1 : 0);
      chk("wen", int'(rf_ren_wen), (cnt == 3 && p_rd != 0) ? 1 : 0);
      if (cnt == 3 && p_rd != 0) chk("waddr", int'(rf_writeaddr), p_rd);
      if (cnt == 1) begin
        chk("raddr1", int'(rf_readaddr1), p_rs);
        chk("raddr2", int'(rf_readaddr2), p_rt);
      end
      chk("acc", int'(acc), m_acc);
      chk("zero", int'(flag_zero), m_zero);
      chk("carry", int'(flag_carry), m_carry);
    end
  end

  int acc_cyc = 0;

  // Presents an instruction and returns just after the accepting edge; valid is left high.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input logic [7:0] imm);
    bit got;
    got = 0;
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
    instr_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (instr_ready) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
        got = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic run(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                     input logic [1:0] rt, input logic [7:0] imm);
    issue(op, rd, rs, rt, imm);
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int a1, a2, a3;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_acc", int'(acc), 0);
    chk("rst_ready", int'(instr_ready), 1);
    chk("rst_wen", int'(rf_ren_wen), 0);
    chk("rst_raddr1", int'(rf_readaddr1), 0);

    // 1: 0x0F + 0x01
    run(3'd7, 2'd1, 2'd0, 2'd0, 8'h0F);
    run(3'd7, 2'd2, 2'd0, 2'd0, 8'h01);
    run(3'd0, 2'd3, 2'd1, 2'd2, 8'h00);
    chk("t1_r3", int'(mem[3]), 8'h10);
    chk("t1_acc", int'(acc), 8'h10);
    chk("t1_carry", int'(flag_carry), 0);
    chk("t1_zero", int'(flag_zero), 0);

    // 2: wrap to zero, then borrow
    run(3'd7, 2'd1, 2'd0, 2'd0, 8'hFF);
    run(3'd0, 2'd1, 2'd1, 2'd2, 8'h00);
    chk("t2_acc", int'(acc), 8'h00);
    chk("t2_carry", int'(flag_carry), 1);
    chk("t2_zero", int'(flag_zero), 1);
    chk("t2_r1", int'(mem[1]), 8'h00);
    run(3'd1, 2'd2, 2'd1, 2'd2, 8'h00);
    chk("t2_sub_acc", int'(acc), 8'hFF);
    chk("t2_borrow", int'(flag_carry), 1);
    chk("t2_r2", int'(mem[2]), 8'hFF);

    // 3: r0 write suppressed, then PASS of r0
    run(3'd7, 2'd1, 2'd0, 2'd0, 8'h77);
    run(3'd7, 2'd0, 2'd0, 2'd0, 8'h55);
    chk("t3_li_acc", int'(acc), 8'h55);
    chk("t3_r0", int'(mem[0]), 8'h00);
    run(3'd6, 2'd1, 2'd0, 2'd0, 8'h00);
    chk("t3_r1", int'(mem[1]), 8'h00);

    // 4: valid held high across three instructions
    issue(3'd7, 2'd2, 2'd0, 2'd0, 8'h21); a1 = acc_cyc;
    issue(3'd0, 2'd3, 2'd2, 2'd2, 8'h00); a2 = acc_cyc;
    issue(3'd1, 2'd1, 2'd3, 2'd2, 8'h00); a3 = acc_cyc;
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_gap1", a2 - a1, 4);
    chk("t4_gap2", a3 - a2, 4);
    chk("t4_r3", int'(mem[3]), 8'h42);
    chk("t4_r1", int'(mem[1]), 8'h21);

    // 5: SLT and self-XOR
    run(3'd7, 2'd1, 2'd0, 2'd0, 8'h03);
    run(3'd7, 2'd2, 2'd0, 2'd0, 8'h80);
    run(3'd5, 2'd3, 2'd1, 2'd2, 8'h00);
    chk("t5_slt", int'(acc), 8'h01);
    run(3'd4, 2'd3, 2'd1, 2'd1, 8'h00);
    chk("t5_xor", int'(acc), 8'h00);
    chk("t5_zero", int'(flag_zero), 1);
    chk("t5_carry", int'(flag_carry), 0);

    // 6: reset during EXEC aborts the instruction
    run(3'd7, 2'd3, 2'd0, 2'd0, 8'hA5);
    issue(3'd0, 2'd3, 2'd1, 2'd2, 8'h00);
    instr_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_acc", int'(acc), 0);
    chk("t6_rst_done", int'(done), 0);
    chk("t6_rst_wen", int'(rf_ren_wen), 0);
    chk("t6_rst_zero", int'(flag_zero), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_ready", int'(instr_ready), 1);
    chk("t6_r3_kept", int'(mem[3]), 8'hA5);
    run(3'd0, 2'd3, 2'd1, 2'd2, 8'h00);
    chk("t6_r3", int'(mem[3]), 8'h83);
    chk("t6_acc", int'(acc), 8'h83);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
